// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with aligned load/store bus handshake and timeout
module mem_access #(
    parameter int          TIMEOUT = 15,
    parameter logic [7:0]  LB      = 8'hE0,
    parameter logic [7:0]  LH      = 8'hE1,
    parameter logic [7:0]  LW      = 8'hE3,
    parameter logic [7:0]  LBU     = 8'hE4,
    parameter logic [7:0]  LHU     = 8'hE5,
    parameter logic [7:0]  SB      = 8'hE8,
    parameter logic [7:0]  SH      = 8'hE9,
    parameter logic [7:0]  SW      = 8'hEB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_sel_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int                WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic        is_load, is_store, is_byte, is_half, is_word, is_mem, misaligned;
    logic        timed_out;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Decode the operation class, access size, bus lanes and load extraction
    always_comb begin
        is_load    = (aluop_i == LB) || (aluop_i == LH) || (aluop_i == LW) ||
                     (aluop_i == LBU) || (aluop_i == LHU);
        is_store   = (aluop_i == SB) || (aluop_i == SH) || (aluop_i == SW);
        is_byte    = (aluop_i == LB) || (aluop_i == LBU) || (aluop_i == SB);
        is_half    = (aluop_i == LH) || (aluop_i == LHU) || (aluop_i == SH);
        is_word    = (aluop_i == LW) || (aluop_i == SW);
        is_mem     = is_load || is_store;
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));

        dmem_sel_o   = 4'b1111;
        dmem_wdata_o = reg2_i;
        if (is_byte) begin
            dmem_sel_o   = 4'b0001 << mem_addr_i[1:0];
            dmem_wdata_o = {4{reg2_i[7:0]}};
        end else if (is_half) begin
            dmem_sel_o   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{reg2_i[15:0]}};
        end

        case (mem_addr_i[1:0])
            2'd0:    load_byte = dmem_rdata_i[7:0];
            2'd1:    load_byte = dmem_rdata_i[15:8];
            2'd2:    load_byte = dmem_rdata_i[23:16];
            default: load_byte = dmem_rdata_i[31:24];
        endcase
        load_half = mem_addr_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

        if (aluop_i == LB)       load_data = {{24{load_byte[7]}}, load_byte};
        else if (aluop_i == LBU) load_data = {24'd0, load_byte};
        else if (aluop_i == LH)  load_data = {{16{load_half[15]}}, load_half};
        else if (aluop_i == LHU) load_data = {16'd0, load_half};
        else                     load_data = dmem_rdata_i;
    end

    assign timed_out   = (wcnt_q == WCNT_MAX);
    assign dmem_addr_o = {mem_addr_i[31:2], 2'b00};
    assign dmem_we_o   = dmem_req_o && is_store;

    // State and registered outputs; reset abandons any in-flight transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next state: enter WAIT on an aligned memory op, leave on ack or timeout
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i && is_mem && !misaligned) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            default: begin
                if (dmem_ack_i || timed_out) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs: stall/request strobes and next writeback values; write enable only on a real result
    always_comb begin
        stallreq_o = 1'b0;
        dmem_req_o = 1'b0;
        wd_d       = wd_q;
        wreg_d     = 1'b0;
        wdata_d    = wdata_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!is_mem) begin
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = wdata_i;
                    end else if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
            end
            default: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    if (is_load) begin
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = load_data;
                    end
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
        endcase
    end

    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign misalign_o = misalign_q;
    assign bus_err_o  = bus_err_q;

endmodule
